// File: rtl/shift_unit_seq_if.sv
// Bus between the control FSM (master) and the iterative shifter (slave).
// The request side is start/op/data_in/shamt; the response side is busy/done/data_out.
interface shift_unit_seq_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy;
   logic        done;
   logic [31:0] data_out;

   modport master (
      output start, op, data_in, shamt,
      input  busy, done, data_out
   );

   modport slave (
      input  start, op, data_in, shamt,
      output busy, done, data_out
   );
endinterface

// File: rtl/shift_unit_seq.sv
// Iterative 32-bit shifter: one bit position per clock, start/busy/done handshake.
// Optional macro SHIFT_UNIT_ROTATE_EN enables rotate-right for op=11; otherwise op=11 moves no bits.
module shift_unit_seq (
   input  logic              clk,
   input  logic              reset,
   shift_unit_seq_if.slave   bus,
   output logic [1:0]        dbg_state
);

   // Handshake: start is sampled on a rising edge and accepted only when not busy
   // (IDLE or DONE); busy is high for each shift cycle; done is high for exactly
   // one cycle per result, and data_out is valid while done is high.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   state_e      state_q, state_d;
   logic [31:0] data_q,  data_d;
   logic [4:0]  count_q, count_d;
   logic [1:0]  op_q,    op_d;
   logic [31:0] shifted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= 32'd0;
         count_q <= 5'd0;
         op_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      shifted = data_q;
      case (op_q)
         OP_SLL:  shifted = {data_q[30:0], 1'b0};
         OP_SRL:  shifted = {1'b0, data_q[31:1]};
         OP_SRA:  shifted = {data_q[31], data_q[31:1]};
         default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
            shifted = {data_q[0], data_q[31:1]};
`else
            shifted = data_q;
`endif
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      op_d    = op_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               data_d  = bus.data_in;
               count_d = bus.shamt;
               op_d    = bus.op;
               state_d = (bus.shamt != 5'd0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            // start is deliberately ignored here so the operation in flight is untouched
            data_d  = shifted;
            count_d = count_q - 5'd1;
            if (count_q == 5'd1) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.busy     = (state_q == S_SHIFT);
   assign bus.done     = (state_q == S_DONE);
   assign bus.data_out = data_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: vector table, hand-written corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_shift_unit_seq;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         tests;
  int         fails;

  shift_unit_seq_if bus ();

  shift_unit_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

`ifdef SHIFT_UNIT_ROTATE_EN
  localparam logic [31:0] ROR_1_BY_1 = 32'h8000_0000;
`else
  localparam logic [31:0] ROR_1_BY_1 = 32'h0000_0001;
`endif

  vec_t vecs [8];

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int n);
    logic signed [31:0] s;
    s = d;
    case (op)
      2'b00: return d << n;
      2'b01: return d >> n;
      2'b10: return 32'(s >>> n);
      default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
        if (n == 0) return d;
        return (d >> n) | (d << (32 - n));
`else
        return d;
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; returns at the negedge where done is seen.
  task automatic finish_op(input string name, input int n, input logic [31:0] exp,
                           input int edges_init, input int busy_init);
    int edges;
    int busy_cnt;
    bit got;
    edges = edges_init;
    busy_cnt = busy_init;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(edges), 32'(n + 1));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
    check({name, "_data"}, bus.data_out, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] din, input logic [4:0] sh);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = din;
    bus.shamt   = sh;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] din,
                        input logic [4:0] sh, input logic [31:0] exp);
    @(negedge clk);
    issue(op, din, sh);
    finish_op(name, int'(sh), exp, 1, 0);
    @(negedge clk);
    check({name, "_done_pulse_width"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_din;
    logic [4:0]  r_sh;
    bit          saw_done;

    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.data_in = 32'd0;
    bus.shamt = 5'd0;

    vecs[0] = '{op: 2'b00, din: 32'h0000_0001, sh: 5'd4,  exp: 32'h0000_0010};
    vecs[1] = '{op: 2'b10, din: 32'h8000_0000, sh: 5'd31, exp: 32'hFFFF_FFFF};
    vecs[2] = '{op: 2'b01, din: 32'h8000_0000, sh: 5'd31, exp: 32'h0000_0001};
    vecs[3] = '{op: 2'b00, din: 32'hDEAD_BEEF, sh: 5'd0,  exp: 32'hDEAD_BEEF};
    vecs[4] = '{op: 2'b11, din: 32'h0000_0001, sh: 5'd1,  exp: ROR_1_BY_1};
    vecs[5] = '{op: 2'b10, din: 32'h7000_0000, sh: 5'd4,  exp: 32'h0700_0000};
    vecs[6] = '{op: 2'b00, din: 32'hFFFF_FFFF, sh: 5'd31, exp: 32'h8000_0000};
    vecs[7] = '{op: 2'b10, din: 32'hF000_00F0, sh: 5'd8,  exp: 32'hFFF0_0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_data", bus.data_out, 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].sh, vecs[i].exp);

    // A start re-pulsed while shifting must be ignored
    @(negedge clk);
    issue(2'b01, 32'h0000_00F0, 5'd4);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 32'd0;
    bus.shamt = 5'd1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    finish_op("ignored_start", 4, 32'h0000_000F, 3, 2);
    @(negedge clk);

    // Back-to-back: start in DONE, including a zero-amount op that keeps done high
    @(negedge clk);
    issue(2'b00, 32'h0000_0001, 5'd2);
    finish_op("b2b_first", 2, 32'h0000_0004, 1, 0);
    issue(2'b00, 32'h1234_5678, 5'd0);
    check("b2b_zero_done_held", 32'(bus.done), 32'd1);
    check("b2b_zero_data", bus.data_out, 32'h1234_5678);
    issue(2'b01, 32'h0000_0100, 5'd3);
    check("b2b_third_done_dropped", 32'(bus.done), 32'd0);
    finish_op("b2b_third", 3, 32'h0000_0020, 1, 0);
    @(negedge clk);

    // Asynchronous reset two cycles into an SLL by 10
    @(negedge clk);
    issue(2'b00, 32'h0000_0001, 5'd10);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_done", 32'(bus.done), 32'd0);
    check("midreset_data", bus.data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("midreset_no_done", 32'(saw_done), 32'd0);
    run_op("after_reset", 2'b00, 32'h0000_0003, 5'd1, 32'h0000_0006);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_din = $urandom;
      r_sh  = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d", i), r_op, r_din, r_sh, ref_shift(r_op, r_din, int'(r_sh)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
